// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl
//   Bit-serial subtractor. It computes a - b (mod 2^WIDTH) one bit per clock,
//   LSB first, through a single combinational full-subtractor cell.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request; sampled when no operation is running
//   a, b   in   WIDTH-bit minuend / subtrahend, captured on acceptance
//   busy   out  high while bits are being processed (exactly WIDTH cycles)
//   done   out  one-cycle pulse when diff/bout are updated
//   diff   out  registered (a - b) mod 2^WIDTH, held until next completion
//   bout   out  final borrow, 1 when a < b (unsigned)

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic             cell_d, cell_bo;
    logic [WIDTH-1:0] acc_shift;
    logic             load;

    full_subtractor u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bo)
    );

    // New result bit enters at the MSB; after WIDTH shifts the LSB of the
    // difference has reached bit 0.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign acc_shift = cell_d;
        end else begin : g_acc_wn
            assign acc_shift = {cell_d, acc_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                load = start;
            end
            SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                acc_d = acc_shift;
                br_d  = cell_bo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    diff_d  = acc_shift;
                    bout_d  = cell_bo;
                    state_d = DONE;
                end
            end
            DONE: begin
                // The edge that closes the done cycle is also the first
                // acceptance point, so a held start gives a WIDTH+1 period.
                state_d = IDLE;
                load    = start;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            sa_d    = a;
            sb_d    = b;
            br_d    = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
module tb_serial_subtract_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st8 = 1'b0, st4 = 1'b0, st1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       a1 = 1'b0, b1 = 1'b0;

    logic       busy8, done8, bout8;
    logic [7:0] diff8;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    serial_subtract_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
    serial_subtract_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4));
    serial_subtract_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));

    int          checks = 0;
    int          failures = 0;
    logic [16:0] exp_q[3][$];       // {bout, diff} per instance
    logic [16:0] hold[3];
    int          run[3];
    longint      cyc = 0;
    longint      done_t[$];         // done cycles of the WIDTH=8 instance

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon(input int i, input int w, input logic bz, input logic dn,
                       input logic [15:0] df, input logic bo);
        logic [16:0] e;
        if (!rst_n) begin
            run[i]  = 0;
            hold[i] = '0;
            chk("reset_outputs", {13'b0, bz, dn, bo, df}, 32'h0);
            return;
        end
        if (dn) begin
            chk("busy_done_exclusive", {31'b0, bz}, 32'h0);
            chk("latency", run[i], w);
            if (exp_q[i].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done inst=%0d actual=done required=no_done", i);
            end else begin
                e = exp_q[i].pop_front();
                chk("diff", {16'b0, df}, {16'b0, e[15:0]});
                chk("bout", {31'b0, bo}, {31'b0, e[16]});
                $display("done inst=%0d diff=%0h bout=%0b expected diff=%0h bout=%0b",
                         i, df, bo, e[15:0], e[16]);
                hold[i] = e;
            end
            run[i] = 0;
            if (i == 0) done_t.push_back(cyc);
        end else begin
            chk("result_hold", {15'b0, bo, df}, {15'b0, hold[i]});
            if (bz) run[i]++;
            else if (run[i] != 0) begin
                chk("busy_ended_without_done", run[i], 0);
                run[i] = 0;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int i, input int w, input int av, input int bv);
        logic [16:0] e;
        int m;
        m = (1 << w) - 1;
        e[15:0] = 16'((av - bv) & m);
        e[16]   = (av < bv);
        exp_q[i].push_back(e);
    endtask

    task automatic op8(input int av, input int bv);
        a8 = 8'(av);
        b8 = 8'(bv);
        push(0, 8, av, bv);
        st8 = 1'b1;
        tick(1);
        st8 = 1'b0;
        tick(10);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                cyc++;
                mon(0, 8, busy8, done8, {8'b0, diff8}, bout8);
                mon(1, 4, busy4, done4, {12'b0, diff4}, bout4);
                mon(2, 1, busy1, done1, {15'b0, diff1}, bout1);
            end
        join_none

        tick(2);
        rst_n = 1'b1;
        chk("reset_state", {20'b0, busy8, done8, bout8, diff8}, 32'h0);

        // basic + borrow cases
        op8(8'h5A, 8'h3C);
        op8(8'h00, 8'h01);
        op8(8'h80, 8'h80);

        // start re-pulsed with new operands mid-operation is ignored
        a8 = 8'h30; b8 = 8'h10;
        push(0, 8, 'h30, 'h10);
        st8 = 1'b1; tick(1); st8 = 1'b0;
        tick(3);
        a8 = 8'hFF; b8 = 8'h00;
        st8 = 1'b1; tick(1); st8 = 1'b0;
        tick(10);
        chk("ignored_start_pending", exp_q[0].size(), 0);
        chk("ignored_start_idle", {31'b0, busy8}, 32'h0);

        // reset in the fourth SHIFT cycle aborts without done
        a8 = 8'h77; b8 = 8'h11;
        st8 = 1'b1; tick(1); st8 = 1'b0;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("abort_clears", {20'b0, busy8, done8, bout8, diff8}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        op8(8'h10, 8'h01);

        // back-to-back with start held high
        a8 = 8'h05; b8 = 8'h03;
        push(0, 8, 'h05, 'h03);
        push(0, 8, 'h03, 'h05);
        st8 = 1'b1;
        tick(1);
        a8 = 8'h03; b8 = 8'h05;
        tick(9);
        st8 = 1'b0;
        tick(12);
        if (done_t.size() >= 2)
            chk("b2b_spacing", 32'(done_t[$] - done_t[$-1]), 32'd9);
        else
            chk("b2b_done_count", done_t.size(), 2);

        // exhaustive WIDTH=1
        for (int av = 0; av < 2; av++) begin
            for (int bv = 0; bv < 2; bv++) begin
                a1 = av[0]; b1 = bv[0];
                push(2, 1, av, bv);
                st1 = 1'b1; tick(1); st1 = 1'b0;
                tick(2);
            end
        end

        // exhaustive WIDTH=4
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                a4 = av[3:0]; b4 = bv[3:0];
                push(1, 4, av, bv);
                st4 = 1'b1; tick(1); st4 = 1'b0;
                tick(5);
            end
        end

        tick(3);
        for (int i = 0; i < 3; i++) chk("queue_drained", exp_q[i].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
